// File: rtl/smt_pkg.sv
// smt_pkg: shared thread-id type and default limits for the SMT fetch scheduler.
package smt_pkg;
   typedef logic tid_t;
   localparam int DEF_MAX_INFLIGHT = 4;
   localparam int DEF_STARVE_LIMIT = 8;
endpackage

// File: rtl/smt_credit_counter.sv
// smt_credit_counter: per-thread outstanding-slot counter, saturating at MAX.
module smt_credit_counter import smt_pkg::*; #(
   parameter int MAX = DEF_MAX_INFLIGHT,
   localparam int W = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         dec,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         full
);
   logic [W-1:0] count_nxt;
   always_comb begin
      full = (count == W'(MAX));
      // simultaneous inc and dec cancel; a dec at zero is dropped
      count_nxt = clr ? '0
                : (inc && !dec && !full) ? count + 1'b1
                : (dec && !inc && count != '0) ? count - 1'b1
                : count;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else        count <= count_nxt;
endmodule

// File: rtl/smt_fetch_sched.sv
// smt_fetch_sched: two-thread fetch slot arbiter with inflight limits,
// anti-starvation priority and count-balancing round robin.
module smt_fetch_sched import smt_pkg::*; #(
   parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
   localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          t0_req,
   input  logic          t1_req,
   input  logic          t0_stall,
   input  logic          t1_stall,
   input  logic          t0_flush,
   input  logic          t1_flush,
   input  logic          t0_retire,
   input  logic          t1_retire,
   input  logic          fetch_ready,
   output logic          fetch_valid,
   output logic          fetch_tid,
   output logic [CW-1:0] t0_inflight,
   output logic [CW-1:0] t1_inflight
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic          t0_full, t1_full, t0_elig, t1_elig, t0_starving, t1_starving, grant;
   logic [SW-1:0] t0_starve, t1_starve;
   tid_t          sel, last_tid;

   always_comb begin
      t0_elig     = t0_req && !t0_stall && !t0_flush && !t0_full;
      t1_elig     = t1_req && !t1_stall && !t1_flush && !t1_full;
      t0_starving = (t0_starve == SW'(STARVE_LIMIT));
      t1_starving = (t1_starve == SW'(STARVE_LIMIT));
      sel = !t1_elig ? 1'b0
          : !t0_elig ? 1'b1
          : (t0_starving != t1_starving) ? t1_starving
          : (t0_inflight != t1_inflight) ? (t1_inflight < t0_inflight)
          : !last_tid;
      // rst_n gates the offer so nothing is presented while in reset
      fetch_valid = rst_n && (t0_elig || t1_elig);
      fetch_tid   = fetch_valid && sel;
      grant       = fetch_valid && fetch_ready;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         t0_starve <= '0;
         t1_starve <= '0;
         last_tid  <= 1'b1;
      end else if (fetch_ready) begin
         t0_starve <= (t0_elig && grant && fetch_tid) ? (t0_starving ? t0_starve : t0_starve + 1'b1) : '0;
         t1_starve <= (t1_elig && grant && !fetch_tid) ? (t1_starving ? t1_starve : t1_starve + 1'b1) : '0;
         if (grant) last_tid <= fetch_tid;
      end

   smt_credit_counter #(.MAX(MAX_INFLIGHT)) u_t0_credit (
      .clk(clk), .rst_n(rst_n), .inc(grant && !fetch_tid), .dec(t0_retire),
      .clr(t0_flush), .count(t0_inflight), .full(t0_full));

   smt_credit_counter #(.MAX(MAX_INFLIGHT)) u_t1_credit (
      .clk(clk), .rst_n(rst_n), .inc(grant && fetch_tid), .dec(t1_retire),
      .clr(t1_flush), .count(t1_inflight), .full(t1_full));
endmodule
